// File: rtl/cnn_pkg.sv
// Shared definitions for the KWS CNN pooling/unpooling stages: default sample width,
// argmax index width helper and the two-state stream FSM encoding.
package cnn_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // Index width for a pooling window; never narrower than one bit.
  function automatic int idx_width(input int stride);
    return (stride <= 2) ? 1 : $clog2(stride);
  endfunction

endpackage

// File: rtl/unpool_lane.sv
// One channel of the unpooling stage: combinational from held value, held argmax and
// phase to the output sample, plus a flag for an argmax outside the pooling window.
module unpool_lane #(
  parameter int DATA_WIDTH = 16,
  parameter int STRIDE     = 2,
  parameter int IDX_W      = 1
) (
  input  logic [DATA_WIDTH-1:0] held_data,
  input  logic [IDX_W-1:0]      held_idx,
  input  logic [IDX_W-1:0]      ph,
  output logic [DATA_WIDTH-1:0] sample,
  output logic                  oor
);

`ifdef MAXUNPOOL_NEAREST_EN
  // Nearest-neighbour upsampling repeats the value on every phase.
  logic unused_sel;
  assign unused_sel = ^{held_idx, ph};
  assign sample     = held_data;
  assign oor        = 1'b0;
`else
  assign oor    = ({1'b0, held_idx} >= (IDX_W + 1)'(STRIDE));
  assign sample = ((held_idx == ph) && !oor) ? held_data : '0;
`endif

endmodule

// File: rtl/maxunpool1d_stream.sv
// Streaming 1-D max-unpool: each accepted beat becomes STRIDE output beats, 1-cycle latency,
// full throughput; stalls hold outputs stable. MAXUNPOOL_NEAREST_EN selects nearest-neighbour.
module maxunpool1d_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CHANNELS   = 32,
  parameter int STRIDE     = 2,
  parameter int IDX_W      = idx_width(STRIDE)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [CHANNELS*IDX_W-1:0]      in_idx,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           out_last,
  output logic                           idx_err
);

  localparam logic [IDX_W-1:0] PH_LAST = IDX_W'(STRIDE - 1);

  state_t                         state;
  state_t                         state_nxt;
  logic [IDX_W-1:0]               ph;
  logic [CHANNELS*DATA_WIDTH-1:0] held_data;
  logic [CHANNELS*IDX_W-1:0]      held_idx;
  logic                           held_last;
  logic [CHANNELS-1:0]            lane_oor;
  logic                           ph_end;
  logic                           accept;
  logic                           out_fire;

  assign ph_end   = (ph == PH_LAST);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EMIT;
      EMIT:    if (out_fire && ph_end) state_nxt = accept ? EMIT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Last phase hands over to the next beat in the same cycle, so no bubble between beats.
  always_comb begin
    in_ready  = (state == IDLE) || ((state == EMIT) && ph_end && out_ready);
    out_valid = (state == EMIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph        <= '0;
      held_data <= '0;
      held_idx  <= '0;
      held_last <= 1'b0;
    end else if (accept) begin
      ph        <= '0;
      held_data <= in_data;
      held_idx  <= in_idx;
      held_last <= in_last;
    end else if (out_fire && !ph_end) begin
      ph <= ph + IDX_W'(1);
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    unpool_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .STRIDE    (STRIDE),
      .IDX_W     (IDX_W)
    ) u_lane (
      .held_data(held_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .held_idx (held_idx[c*IDX_W +: IDX_W]),
      .ph       (ph),
      .sample   (out_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .oor      (lane_oor[c])
    );
  end

  assign out_last = held_last && ph_end;

`ifdef MAXUNPOOL_NEAREST_EN
  logic unused_oor;
  assign unused_oor = |lane_oor;
  assign idx_err    = 1'b0;
`else
  // Flag is raised while the offending beat is held; it stays set until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_err <= 1'b0;
    end else if ((state == EMIT) && (|lane_oor)) begin
      idx_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_maxunpool1d_stream.sv
// Directed bench: stride-2 instance for unpool/throughput/backpressure/frame/reset,
// stride-3 instance for out-of-range argmax; nearest-mode expectations under the macro.
module tb_maxunpool1d_stream;

  localparam int DW = 16;
  localparam int CH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            a_in_valid, a_in_ready, a_in_last;
  logic [CH*DW-1:0] a_in_data, a_out_data;
  logic [CH-1:0]    a_in_idx;
  logic            a_out_valid, a_out_ready, a_out_last, a_idx_err;

  logic            b_in_valid, b_in_ready, b_in_last;
  logic [CH*DW-1:0] b_in_data, b_out_data;
  logic [2*CH-1:0]  b_in_idx;
  logic            b_out_valid, b_out_ready, b_out_last, b_idx_err;

  maxunpool1d_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .STRIDE(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_idx(a_in_idx), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_last(a_out_last), .idx_err(a_idx_err)
  );

  maxunpool1d_stream #(.DATA_WIDTH(DW), .CHANNELS(CH), .STRIDE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_idx(b_in_idx), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .idx_err(b_idx_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_lane(input logic [DW-1:0] d, input int idx, input int ph);
`ifdef MAXUNPOOL_NEAREST_EN
    if (idx < 0 || ph < 0) return '0;
    return d;
`else
    return (idx == ph) ? d : '0;
`endif
  endfunction

  function automatic logic [CH*DW-1:0] exp_beat(input logic [CH*DW-1:0] d, input logic [CH-1:0] idx,
                                               input int ph);
    logic [CH*DW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) r[c*DW +: DW] = exp_lane(d[c*DW +: DW], int'(idx[c]), ph);
    return r;
  endfunction

  typedef struct {
    logic [CH*DW-1:0] d;
    logic             last;
    int               ph;
  } exp_t;

  exp_t             q[$];
  logic [CH*DW-1:0] bt_data[4];
  logic [CH-1:0]    bt_idx[4];
  logic             bt_last[4];

  // Streams nb beats into the stride-2 instance; out_ready is low for cycles [stall_at, stall_at+stall_len).
  task automatic run_a(input int nb, input int stall_at, input int stall_len, input int budget,
                       output int first_cyc, output int last_cyc, output int last_pos, output int n_last);
    int   sent, cyc, nout;
    logic acc, fire, exp_rdy;
    exp_t e;
    sent = 0; cyc = 0; nout = 0;
    first_cyc = -1; last_cyc = -1; last_pos = -1; n_last = 0;
    @(posedge clk); #1;
    a_in_valid  = 1'b1;
    a_in_data   = bt_data[0];
    a_in_idx    = bt_idx[0];
    a_in_last   = bt_last[0];
    a_out_ready = !(stall_len > 0 && stall_at == 0);
    while ((sent < nb || q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      acc     = a_in_valid && a_in_ready;
      exp_rdy = (q.size() == 0) || (q[0].ph == 1 && a_out_ready);
      chk("in_ready", a_in_ready, exp_rdy);
      if (q.size() == 0) begin
        chk("out_valid_idle", a_out_valid, 1'b0);
      end else begin
        chk("out_valid", a_out_valid, 1'b1);
        chk("out_data", a_out_data, q[0].d);
        chk("out_last", a_out_last, q[0].last);
      end
      fire = a_out_valid && a_out_ready;
      if (fire) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        if (a_out_last) begin
          last_pos = nout;
          n_last++;
        end
        nout++;
        if (q.size() > 0) void'(q.pop_front());
      end
      if (acc) begin
        for (int p = 0; p < 2; p++) begin
          e.d    = exp_beat(bt_data[sent], bt_idx[sent], p);
          e.last = bt_last[sent] && (p == 1);
          e.ph   = p;
          q.push_back(e);
        end
        sent++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (sent < nb) begin
          a_in_data = bt_data[sent];
          a_in_idx  = bt_idx[sent];
          a_in_last = bt_last[sent];
        end else begin
          a_in_valid = 1'b0;
        end
      end
      cyc++;
      a_out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
    end
    chk("stream_complete", {63'd0, (sent == nb && q.size() == 0)}, 64'd1);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc, lc, lp, nl;
    a_in_valid = 0; a_in_last = 0; a_in_data = '0; a_in_idx = '0; a_out_ready = 1;
    b_in_valid = 0; b_in_last = 0; b_in_data = '0; b_in_idx = '0; b_out_ready = 1;

    bt_data[0] = 64'h1111_2222_3333_4444; bt_idx[0] = 4'b0101;
    bt_data[1] = 64'hAAAA_BBBB_CCCC_DDDD; bt_idx[1] = 4'b1100;
    bt_data[2] = 64'h0001_8000_FFFF_7F7F; bt_idx[2] = 4'b0011;
    bt_data[3] = 64'hDEAD_BEEF_CAFE_F00D; bt_idx[3] = 4'b1010;

    // Reset state
    #3;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_out_data", a_out_data, 64'd0);
    chk("rst_out_last", a_out_last, 1'b0);
    chk("rst_idx_err", a_idx_err, 1'b0);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic unpool: ch0=0x1234 idx1, ch1=0x00FF idx0
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = 64'h0000_0000_00FF_1234; a_in_idx = 4'b0001; a_in_last = 1'b0;
    @(negedge clk);
    chk("basic_accept_rdy", a_in_ready, 1'b1);
    chk("basic_pre_valid", a_out_valid, 1'b0);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("basic_b0_valid", a_out_valid, 1'b1);
`ifdef MAXUNPOOL_NEAREST_EN
    chk("basic_b0_data", a_out_data, 64'h0000_0000_00FF_1234);
`else
    chk("basic_b0_data", a_out_data, 64'h0000_0000_00FF_0000);
`endif
    chk("basic_b0_rdy", a_in_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("basic_b1_valid", a_out_valid, 1'b1);
`ifdef MAXUNPOOL_NEAREST_EN
    chk("basic_b1_data", a_out_data, 64'h0000_0000_00FF_1234);
`else
    chk("basic_b1_data", a_out_data, 64'h0000_0000_0000_1234);
`endif
    chk("basic_b1_rdy", a_in_ready, 1'b1);
    chk("basic_b1_last", a_out_last, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("basic_idle", a_out_valid, 1'b0);

    // Back-to-back with frame end on the 3rd beat
    bt_last[0] = 0; bt_last[1] = 0; bt_last[2] = 1; bt_last[3] = 0;
    run_a(4, 0, 0, 40, fc, lc, lp, nl);
    chk("b2b_first_out_cycle", 64'(fc), 64'd1);
    chk("b2b_no_bubble_span", 64'(lc - fc), 64'd7);
    chk("frame_last_pos", 64'(lp), 64'd5);
    chk("frame_last_count", 64'(nl), 64'd1);

    // Backpressure: out_ready low for 3 cycles mid-emission
    bt_last[2] = 0; bt_last[3] = 1;
    run_a(4, 2, 3, 40, fc, lc, lp, nl);
    chk("bp_span", 64'(lc - fc), 64'd10);
    chk("bp_last_pos", 64'(lp), 64'd7);
    chk("bp_no_err", a_idx_err, 1'b0);

    // Stride 3: ch0 idx0, ch1 idx2, ch2 idx3 (out of range), ch3 idx1
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_data = 64'h4444_3333_2222_1111; b_in_idx = 8'b01_11_10_00; b_in_last = 1'b1;
    @(negedge clk);
    chk("s3_rdy", b_in_ready, 1'b1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      chk("s3_valid", b_out_valid, 1'b1);
      chk("s3_last", b_out_last, (p == 2));
`ifdef MAXUNPOOL_NEAREST_EN
      chk("s3_data", b_out_data, 64'h4444_3333_2222_1111);
`else
      case (p)
        0:       chk("s3_data_ph0", b_out_data, 64'h0000_0000_0000_1111);
        1:       chk("s3_data_ph1", b_out_data, 64'h4444_0000_0000_0000);
        default: chk("s3_data_ph2", b_out_data, 64'h0000_0000_2222_0000);
      endcase
`endif
      @(posedge clk);
    end
    @(negedge clk);
    chk("s3_idle", b_out_valid, 1'b0);
`ifdef MAXUNPOOL_NEAREST_EN
    chk("s3_idx_err", b_idx_err, 1'b0);
`else
    chk("s3_idx_err", b_idx_err, 1'b1);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef MAXUNPOOL_NEAREST_EN
    chk("s3_idx_err_sticky", b_idx_err, 1'b0);
`else
    chk("s3_idx_err_sticky", b_idx_err, 1'b1);
`endif

    // ch0=0xABCD idx1, then reset pulsed during phase 1
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_data = 64'h0000_0000_0000_ABCD; a_in_idx = 4'b0001; a_in_last = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(negedge clk);
`ifdef MAXUNPOOL_NEAREST_EN
    chk("abcd_ph0", a_out_data, 64'h0000_0000_0000_ABCD);
`else
    chk("abcd_ph0", a_out_data, 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    chk("abcd_ph1", a_out_data, 64'h0000_0000_0000_ABCD);
    chk("abcd_ph1_valid", a_out_valid, 1'b1);
    chk("abcd_no_err", a_idx_err, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", a_out_valid, 1'b0);
    chk("midrst_in_ready", a_in_ready, 1'b1);
    chk("midrst_out_data", a_out_data, 64'd0);
    chk("midrst_b_idx_err", b_idx_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst_out_valid", a_out_valid, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
